// File: rtl/compare_arbiter_pkg.sv
// Shared definitions for the compare arbiter: result bit positions, result type
// and the default requester count.
package compare_arbiter_pkg;

  localparam int CMP_GT = 2;
  localparam int CMP_EQ = 1;
  localparam int CMP_LT = 0;

  localparam int N_REQ_DEFAULT = 4;

  typedef logic [2:0] cmp_t;

endpackage

// File: rtl/comparator4.sv
// 4-bit magnitude comparator; exactly one of {gt,eq,lt} is set in c.
module comparator4
  import compare_arbiter_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output cmp_t       c
);

  always_comb begin
    c         = '0;
    c[CMP_GT] = (a > b);
    c[CMP_EQ] = (a == b);
    c[CMP_LT] = (a < b);
  end

endmodule

// File: rtl/compare_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, with wrap,
// returned as a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req,
  input  logic [IDW-1:0] ptr,
  output logic [N-1:0]   grant,
  output logic [IDW-1:0] grant_idx,
  output logic           grant_valid
);

  int             j;
  logic [IDW-1:0] jj;

  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    j           = 0;
    jj          = '0;
    for (int k = 0; k < N; k++) begin
      j = int'(ptr) + k;
      if (j >= N) begin
        j = j - N;
      end
      jj = IDW'(j);
      if (!grant_valid && req[jj]) begin
        grant_valid = 1'b1;
        grant[jj]   = 1'b1;
        grant_idx   = jj;
      end
    end
  end

endmodule

// File: rtl/compare_arbiter.sv
// Round-robin sharing of one comparator4 among N_REQ requesters with a single
// registered, id-tagged result slot. Optional grant counters: CMP_STATS_EN.
module compare_arbiter
  import compare_arbiter_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEFAULT,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [4*N_REQ-1:0]   req_a,
  input  logic [4*N_REQ-1:0]   req_b,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 rsp_valid,
  output logic [IDW-1:0]       rsp_id,
  output logic [2:0]           rsp_cmp,
  input  logic                 rsp_ready
`ifdef CMP_STATS_EN
  ,
  output logic [8*N_REQ-1:0]   stat_grants
`endif
);

  logic           rsp_valid_q, rsp_valid_d;
  logic [IDW-1:0] rsp_id_q, rsp_id_d;
  cmp_t           rsp_cmp_q, rsp_cmp_d;
  logic [IDW-1:0] rr_ptr_q, rr_ptr_d;

  logic [3:0]       a_arr [N_REQ];
  logic [3:0]       b_arr [N_REQ];
  logic             free;
  logic [N_REQ-1:0] grant;
  logic [IDW-1:0]   grant_idx;
  logic             accept;
  logic [3:0]       a_sel, b_sel;
  cmp_t             cmp_c;

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign a_arr[gi] = req_a[4*gi +: 4];
      assign b_arr[gi] = req_b[4*gi +: 4];
    end
  endgenerate

  // A pop and a new accept may share an edge, so the slot counts as free
  // whenever the consumer is taking the held result.
  assign free = !rsp_valid_q || rsp_ready;

  rr_arbiter #(
    .N   (N_REQ),
    .IDW (IDW)
  ) u_rr_arbiter (
    .req         (req_valid & {N_REQ{free}}),
    .ptr         (rr_ptr_q),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (accept)
  );

  assign req_ready = grant;
  assign a_sel     = a_arr[grant_idx];
  assign b_sel     = b_arr[grant_idx];

  comparator4 u_comparator4 (
    .a (a_sel),
    .b (b_sel),
    .c (cmp_c)
  );

  always_comb begin
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_cmp_d   = rsp_cmp_q;
    rr_ptr_d    = rr_ptr_q;
    if (accept) begin
      rsp_valid_d = 1'b1;
      rsp_id_d    = grant_idx;
      rsp_cmp_d   = cmp_c;
      rr_ptr_d    = (grant_idx == IDW'(N_REQ - 1)) ? '0 : grant_idx + IDW'(1);
    end else if (rsp_ready) begin
      rsp_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_cmp_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_cmp_q   <= rsp_cmp_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_cmp   = rsp_cmp_q;

`ifdef CMP_STATS_EN
  logic [7:0] stat_q [N_REQ];

  generate
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_stats
      always_ff @(posedge clk) begin
        if (rst) begin
          stat_q[gi] <= '0;
        end else if (grant[gi] && (stat_q[gi] != 8'hFF)) begin
          stat_q[gi] <= stat_q[gi] + 8'd1;
        end
      end
      assign stat_grants[8*gi +: 8] = stat_q[gi];
    end
  endgenerate
`endif

endmodule

// File: tb/tb_compare_arbiter.sv
// Directed self-checking bench for compare_arbiter (N_REQ=4); the counter
// section is built only when CMP_STATS_EN is defined.
module tb_compare_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic           rsp_valid;
  logic [1:0]     rsp_id;
  logic [2:0]     rsp_cmp;
  logic           rsp_ready;
`ifdef CMP_STATS_EN
  logic [8*N-1:0] stat_grants;
`endif

  int n_total = 0;
  int n_pass  = 0;

  compare_arbiter #(.N_REQ(N), .IDW(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_id      (rsp_id),
    .rsp_cmp     (rsp_cmp),
    .rsp_ready   (rsp_ready)
`ifdef CMP_STATS_EN
    ,
    .stat_grants (stat_grants)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) begin
      n_pass++;
      $display("check %s observed=%0h expected=%0h ok", tag, obs, exp);
    end else begin
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and settle 1 time unit past the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  logic [2:0] exp_cmp [N];
  int         exp_g;

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b0;
    do_reset();

    // 1. Idle after reset
    for (int i = 0; i < 5; i++) begin
      chk("idle_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("idle_req_ready", 32'(req_ready), 32'd0);
      step();
    end
    chk("idle_rsp_id", 32'(rsp_id), 32'd0);
    chk("idle_rsp_cmp", 32'(rsp_cmp), 32'd0);

    // 2. Single requests: gt, lt, eq
    rsp_ready = 1'b1;
    req_valid = 4'b0001;
    req_a[3:0] = 4'h1; req_b[3:0] = 4'h0;
    #1;
    chk("single_gt_ready", 32'(req_ready), 32'b0001);
    step();
    chk("single_gt_valid", 32'(rsp_valid), 32'd1);
    chk("single_gt_id", 32'(rsp_id), 32'd0);
    chk("single_gt_cmp", 32'(rsp_cmp), 32'b100);

    req_a[3:0] = 4'h0; req_b[3:0] = 4'h1;
    #1;
    chk("single_lt_ready", 32'(req_ready), 32'b0001);
    step();
    chk("single_lt_cmp", 32'(rsp_cmp), 32'b001);

    req_a[3:0] = 4'hA; req_b[3:0] = 4'hA;
    #1;
    chk("single_eq_ready", 32'(req_ready), 32'b0001);
    step();
    chk("single_eq_cmp", 32'(rsp_cmp), 32'b010);

    req_valid = '0;
    #1;
    chk("no_req_ready", 32'(req_ready), 32'd0);
    step();
    chk("pop_only_valid", 32'(rsp_valid), 32'd0);
    chk("pop_only_cmp_kept", 32'(rsp_cmp), 32'b010);

    // 3. All requesters valid: rotation 0,1,2,3,0
    do_reset();
    req_a = {4'h0, 4'hF, 4'h7, 4'h3};
    req_b = {4'h0, 4'h0, 4'h7, 4'h5};
    exp_cmp[0] = 3'b001;
    exp_cmp[1] = 3'b010;
    exp_cmp[2] = 3'b100;
    exp_cmp[3] = 3'b010;
    rsp_ready = 1'b1;
    req_valid = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      exp_g = i % N;
      #1;
      chk("rr_grant", 32'(req_ready), 32'(1 << exp_g));
      step();
      chk("rr_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("rr_rsp_id", 32'(rsp_id), 32'(exp_g));
      chk("rr_rsp_cmp", 32'(rsp_cmp), 32'(exp_cmp[exp_g]));
    end

    // 4. Back-pressure with req1/req2 pending; held result is id0 / 3'b001
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      chk("bp_rsp_id", 32'(rsp_id), 32'd0);
      chk("bp_rsp_cmp", 32'(rsp_cmp), 32'b001);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_grant", 32'(req_ready), 32'b0010);
    step();
    chk("bp_release_id", 32'(rsp_id), 32'd1);
    chk("bp_release_cmp", 32'(rsp_cmp), 32'b010);

    // 5. Reset while a result is held and req3 is pending (rr_ptr is 2 here)
    req_valid = 4'b1000;
    rsp_ready = 1'b0;
    #1;
    chk("mid_pre_valid", 32'(rsp_valid), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_id", 32'(rsp_id), 32'd0);
    chk("mid_rst_cmp", 32'(rsp_cmp), 32'd0);
    req_valid = 4'b1010;
    rsp_ready = 1'b1;
    #1;
    chk("mid_first_grant", 32'(req_ready), 32'b0010);
    step();
    chk("mid_first_id", 32'(rsp_id), 32'd1);

`ifdef CMP_STATS_EN
    // 6. Saturating grant counters
    do_reset();
    req_valid = 4'b0100;
    rsp_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      step();
    end
    req_valid = '0;
    step();
    chk("stat_req2_sat", 32'(stat_grants[23:16]), 32'hFF);
    chk("stat_req0", 32'(stat_grants[7:0]), 32'd0);
    chk("stat_req1", 32'(stat_grants[15:8]), 32'd0);
    chk("stat_req3", 32'(stat_grants[31:24]), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("stat_rst_clear", stat_grants, 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
